// File: rtl/pwm_ramp_ctrl_if.sv
// Control/status bundle between a motor supervisor and pwm_ramp_ctrl.
// Latency: none; this is a plain wire bundle.
// Backpressure: none; pulses are single-cycle, fault is a level, status is registered in the block.
// Ports: start/stop/fault_clr requests, fault level, target_duty, wrap pulse (master -> slave);
//        pwm_en, duty_cycle, state, fault_latched status (slave -> master).
interface pwm_ramp_ctrl_if;
  logic       start;
  logic       stop;
  logic       fault;
  logic       fault_clr;
  logic [7:0] target_duty;
  logic       wrap;
  logic       pwm_en;
  logic [7:0] duty_cycle;
  logic [2:0] state;
  logic       fault_latched;

  modport master (
    output start, stop, fault, fault_clr, target_duty, wrap,
    input  pwm_en, duty_cycle, state, fault_latched
  );

  modport slave (
    input  start, stop, fault, fault_clr, target_duty, wrap,
    output pwm_en, duty_cycle, state, fault_latched
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty ramp controller for a three-phase PWM bank.
// Latency: all outputs registered, one cycle after the sampled cause.
// Backpressure: none; requests are sampled every cycle, priority fault > stop > start.
// Ports: clk, rst (sync, active-high); bus (slave) carries requests, target duty,
//        the PWM wrap pulse, and pwm_en/duty_cycle/state/fault_latched status.
module pwm_ramp_ctrl #(
  parameter int unsigned STEP = 1,  // duty change per ramp step, 1..255
  parameter int unsigned DIV  = 4   // wrap pulses per ramp step, 1..255
) (
  input logic            clk,
  input logic            rst,
  pwm_ramp_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam logic [8:0] STEP9    = 9'(STEP);
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] duty_q, duty_d;
  logic [7:0] presc_q, presc_d;
  logic       pwm_en_q, pwm_en_d;
  logic       fault_q, fault_d;
  logic       tick;

  logic [8:0] up_sum, dn_dif;
  logic [7:0] up_sat, dn_sat, toward_tgt;

  // Ramp arithmetic in 9 bits: bit 8 of the sum is overflow, bit 8 of the
  // difference is borrow, so both saturate without wrapping.
  always_comb begin
    up_sum = {1'b0, duty_q} + STEP9;
    dn_dif = {1'b0, duty_q} - STEP9;
    up_sat = up_sum[8] ? 8'hFF : up_sum[7:0];
    dn_sat = dn_dif[8] ? 8'h00 : dn_dif[7:0];
    if (duty_q < bus.target_duty) begin
      toward_tgt = (up_sat > bus.target_duty) ? bus.target_duty : up_sat;
    end else if (duty_q > bus.target_duty) begin
      toward_tgt = (dn_sat < bus.target_duty) ? bus.target_duty : dn_sat;
    end else begin
      toward_tgt = duty_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.fault) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (bus.stop)                             state_d = RAMP_DOWN;
          else if (duty_q == bus.target_duty)       state_d = RUN;
        end
        RUN: begin
          if (bus.stop) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          // stop outranks start, so a coincident pair keeps ramping down
          if (bus.start && !bus.stop) state_d = RAMP_UP;
          else if (duty_q == 8'd0)    state_d = IDLE;
        end
        FAULT: begin
          if (bus.fault_clr) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler and duty update. A state change restarts the prescaler and
  // suppresses any step, so a wrap landing on a transition is not applied.
  always_comb begin
    presc_d = presc_q;
    duty_d  = duty_q;
    tick    = bus.wrap && (presc_q == DIV_LAST);
    if (state_d != state_q) begin
      presc_d = 8'd0;
    end else begin
      if (bus.wrap) presc_d = tick ? 8'd0 : presc_q + 8'd1;
      if (tick) begin
        case (state_q)
          RAMP_UP, RUN: duty_d = toward_tgt;
          RAMP_DOWN:    duty_d = dn_sat;
          default:      duty_d = duty_q;
        endcase
      end
    end
    if (state_d == IDLE || state_d == FAULT) duty_d = 8'd0;
    pwm_en_d = (state_d == RAMP_UP) || (state_d == RUN) || (state_d == RAMP_DOWN);
    fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= 8'd0;
      presc_q  <= 8'd0;
      pwm_en_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      presc_q  <= presc_d;
      pwm_en_q <= pwm_en_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.duty_cycle    = duty_q;
  assign bus.pwm_en        = pwm_en_q;
  assign bus.fault_latched = fault_q;

endmodule
